// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the TX and RX paths: FSM state
// encodings, line-level constants, parity-type constants and a parity helper.
package uart_pkg;

    // Widest payload any UART block in this slice supports
    localparam int MAX_DATA_W = 9;

    // Serial line levels
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Parity type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Frame sequencer states; ST_STOP2 is only reachable in two-stop-bit builds
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_STOP2  = 3'd5
    } uart_state_e;

    // Parity bit for a payload zero-extended to MAX_DATA_W bits.
    // Zero extension leaves the XOR reduction unchanged, so one function
    // serves every legal payload width.
    function automatic logic calcParity(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  parTyp);
        logic evenBit;
        evenBit = ^data;
        return (parTyp == PAR_ODD) ? ~evenBit : evenBit;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register and bit counter for the UART transmitter.
// The controller loads a word, then shifts it out LSB first; ser_data is
// always the bit that will be placed on the line next. The counter tracks
// which data bit is currently on the line and is cleared by the controller
// when the frame leaves the data phase.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              count,
    input  logic              clear,
    output logic              ser_data,
    output logic              ser_done
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] r_shiftReg;
    logic [CNT_W-1:0]  r_bitCnt;

    // Shift register: parallel load on accept, logical right shift per data bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shiftReg <= '0;
        end else if (load) begin
            r_shiftReg <= load_data;
        end else if (shift) begin
            r_shiftReg <= {1'b0, r_shiftReg[DATA_W-1:1]};
        end
    end

    // Bit counter: index of the data bit on the line, never wraps inside a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt <= '0;
        end else if (load || clear) begin
            r_bitCnt <= '0;
        end else if (count) begin
            r_bitCnt <= r_bitCnt + 1'b1;
        end
    end

    assign ser_data = r_shiftReg[0];
    assign ser_done = (r_bitCnt == LAST_BIT);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer. Accepts a parallel word when idle, latches
// its parity and parity enable, and sends start / data (LSB first) /
// optional parity / stop, one bit per CLK. All outputs are registered.
// Build option: define UART_TX_STOP2_EN to append a second stop bit; the
// frame_done pulse then moves to the second stop cycle.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              DATA_VALID,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic              TX_OUT,
    output logic              busy,
    output logic              frame_done
);

`ifdef UART_TX_STOP2_EN
    localparam logic DONE_IN_STOP = 1'b0;
`else
    localparam logic DONE_IN_STOP = 1'b1;
`endif

    uart_state_e r_state;
    uart_state_e w_nextState;

    logic r_txOut;
    logic r_busy;
    logic r_frameDone;
    logic r_parity;
    logic r_parEn;

    logic w_txNext;
    logic w_busyNext;
    logic w_doneNext;
    logic w_accept;
    logic w_load;
    logic w_shift;
    logic w_count;
    logic w_clear;
    logic w_serData;
    logic w_serDone;

    assign w_accept = (r_state == ST_IDLE) && DATA_VALID && !r_busy;

    uart_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_serializer (
        .clk       (CLK),
        .rst       (RST),
        .load      (w_load),
        .load_data (P_DATA),
        .shift     (w_shift),
        .count     (w_count),
        .clear     (w_clear),
        .ser_data  (w_serData),
        .ser_done  (w_serDone)
    );

    // State and registered outputs; reset aborts any frame and idles the line
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_txOut     <= LINE_IDLE;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_txOut     <= w_txNext;
            r_busy      <= w_busyNext;
            r_frameDone <= w_doneNext;
        end
    end

    // Frame options captured at accept so later input changes cannot alter the frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_parity <= 1'b0;
            r_parEn  <= 1'b0;
        end else if (w_load) begin
            r_parity <= calcParity(MAX_DATA_W'(P_DATA), PAR_TYP);
            r_parEn  <= PAR_EN;
        end
    end

    // Next state plus the line level, busy and done values for the next cycle
    always_comb begin
        w_nextState = r_state;
        w_txNext    = LINE_IDLE;
        w_busyNext  = 1'b1;
        w_doneNext  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_count     = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busyNext = 1'b0;
                if (w_accept) begin
                    w_nextState = ST_START;
                    w_txNext    = LINE_START;
                    w_busyNext  = 1'b1;
                    w_load      = 1'b1;
                end
            end

            ST_START: begin
                w_nextState = ST_DATA;
                w_txNext    = w_serData;
                w_shift     = 1'b1;
            end

            ST_DATA: begin
                if (w_serDone) begin
                    w_clear = 1'b1;
                    if (r_parEn) begin
                        w_nextState = ST_PARITY;
                        w_txNext    = r_parity;
                    end else begin
                        w_nextState = ST_STOP;
                        w_txNext    = LINE_IDLE;
                        w_doneNext  = DONE_IN_STOP;
                    end
                end else begin
                    w_txNext = w_serData;
                    w_shift  = 1'b1;
                    w_count  = 1'b1;
                end
            end

            ST_PARITY: begin
                w_nextState = ST_STOP;
                w_txNext    = LINE_IDLE;
                w_doneNext  = DONE_IN_STOP;
            end

            ST_STOP: begin
`ifdef UART_TX_STOP2_EN
                w_nextState = ST_STOP2;
                w_txNext    = LINE_IDLE;
                w_doneNext  = 1'b1;
`else
                w_nextState = ST_IDLE;
                w_busyNext  = 1'b0;
`endif
            end

            default: begin
                w_nextState = ST_IDLE;
                w_busyNext  = 1'b0;
            end
        endcase
    end

    assign TX_OUT     = r_txOut;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed testbench for uart_tx_ctrl. Expected line sequences are written
// out by hand, first bit (T1) on the left; unused trailing positions are 1.
// Define UART_TX_STOP2_EN for both bench and RTL to check two-stop builds.
module tb_uart_tx_ctrl;

    localparam int DATA_W = 8;
`ifdef UART_TX_STOP2_EN
    localparam int EXTRA_STOP = 1;
`else
    localparam int EXTRA_STOP = 0;
`endif

    logic              CLK;
    logic              RST;
    logic              DATA_VALID;
    logic [DATA_W-1:0] P_DATA;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              TX_OUT;
    logic              busy;
    logic              frame_done;

    int vectors;
    int miscompares;

    uart_tx_ctrl #(
        .DATA_W (DATA_W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .DATA_VALID (DATA_VALID),
        .P_DATA     (P_DATA),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Free-running baud clock, 10 time units per bit
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge so registered outputs are settled
    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    // Compare all three outputs against hand-computed values
    task automatic checkOutput(input string tag, input logic expTx,
                               input logic expBusy, input logic expDone);
        vectors++;
        assert (TX_OUT === expTx) else begin
            miscompares++;
            $error("FAIL %s TX_OUT observed=%b expected=%b", tag, TX_OUT, expTx);
        end
        vectors++;
        assert (busy === expBusy) else begin
            miscompares++;
            $error("FAIL %s busy observed=%b expected=%b", tag, busy, expBusy);
        end
        vectors++;
        assert (frame_done === expDone) else begin
            miscompares++;
            $error("FAIL %s frame_done observed=%b expected=%b", tag, frame_done, expDone);
        end
    endtask

    // Offer a word for one cycle from an idle cycle; returns positioned in T1
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic en,
                                 input logic typ);
        DATA_VALID = 1'b1;
        P_DATA     = data;
        PAR_EN     = en;
        PAR_TYP    = typ;
        nextCycle();
    endtask

    // Check a frame from T1 through the idle cycle after it; optionally
    // disturb P_DATA/PAR_TYP at frame position changeAt (0 = T1)
    task automatic runFrame(input string tag, input logic [0:15] expBits,
                            input int len, input int changeAt,
                            input logic [DATA_W-1:0] newData, input logic newTyp);
        for (int i = 0; i < len; i++) begin
            if (i == changeAt) begin
                P_DATA  = newData;
                PAR_TYP = newTyp;
            end
            checkOutput($sformatf("%s T%0d", tag, i + 1), expBits[i], 1'b1,
                        (i == len - 1));
            nextCycle();
        end
        checkOutput($sformatf("%s idle", tag), 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset for two edges while a word is being offered
        RST        = 1'b1;
        DATA_VALID = 1'b1;
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b0;
        nextCycle();
        checkOutput("reset c1", 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("reset c2", 1'b1, 1'b0, 1'b0);
        RST        = 1'b0;
        DATA_VALID = 1'b0;
        nextCycle();
        checkOutput("post-reset c1", 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("post-reset c2", 1'b1, 1'b0, 1'b0);

        // A5 with even parity
        $display("[TB] frame A5 even parity");
        applyStimulus(8'hA5, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        runFrame("a5 even", 16'b0_10100101_0_1_11111, 11 + EXTRA_STOP, -1, 8'h00, 1'b0);

        // A5 with odd parity
        $display("[TB] frame A5 odd parity");
        applyStimulus(8'hA5, 1'b1, 1'b1);
        DATA_VALID = 1'b0;
        runFrame("a5 odd", 16'b0_10100101_1_1_11111, 11 + EXTRA_STOP, -1, 8'h00, 1'b0);

        // FF without parity
        $display("[TB] frame FF no parity");
        applyStimulus(8'hFF, 1'b0, 1'b0);
        DATA_VALID = 1'b0;
        runFrame("ff nopar", 16'b0_11111111_1_111111, 10 + EXTRA_STOP, -1, 8'h00, 1'b0);

        // 3C held valid, inputs changed to C3/odd at T3, C3 accepted in idle gap
        $display("[TB] frame 3C with mid-frame input change, then C3");
        applyStimulus(8'h3C, 1'b1, 1'b0);
        runFrame("3c", 16'b0_00111100_0_1_11111, 11 + EXTRA_STOP, 2, 8'hC3, 1'b1);
        nextCycle();
        DATA_VALID = 1'b0;
        runFrame("c3", 16'b0_11000011_1_1_11111, 11 + EXTRA_STOP, -1, 8'h00, 1'b0);

        // Reset asserted at T5 of a 55 frame
        $display("[TB] reset mid-frame");
        applyStimulus(8'h55, 1'b1, 1'b0);
        DATA_VALID = 1'b0;
        checkOutput("abort T1", 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("abort T2", 1'b1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("abort T3", 1'b0, 1'b1, 1'b0);
        nextCycle();
        checkOutput("abort T4", 1'b1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("abort T5", 1'b0, 1'b1, 1'b0);
        RST = 1'b1;
        nextCycle();
        checkOutput("abort T6", 1'b1, 1'b0, 1'b0);
        RST = 1'b0;
        nextCycle();
        checkOutput("abort T7", 1'b1, 1'b0, 1'b0);

        // Fresh 01 frame after the abort
        $display("[TB] frame 01 after abort");
        applyStimulus(8'h01, 1'b0, 1'b0);
        DATA_VALID = 1'b0;
        runFrame("01 nopar", 16'b0_10000000_1_111111, 10 + EXTRA_STOP, -1, 8'h00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
